dmux_stream: RTL and testbench
==============================

// Module: dmux_stream
// PURPOSE
//   Registered, parametrised N-way demultiplexer for valid/ready streams; generalises the
//   combinational 8-way dmux to WIDTH-bit beats, NCH channels and per-channel backpressure.
//   Routes each input beat (or whole packet) to the channel given by in_sel. Each channel has
//   a one-entry output register. Sits between a single producer and NCH independent consumers.
// PARAMETERS
//   WIDTH   16  data bits per beat
//   NCH     8   number of output channels, 2..64
//   SELW    3   select width, >= clog2(NCH)
//   PACKET  1   1 = route per packet (sel sampled on first beat, held to in_last); 0 = per beat
// PORTS
//   clk        in   1          single clock, all state on rising edge
//   reset      in   1          asynchronous, active-high reset
//   in_data    in   WIDTH      input beat
//   in_valid   in   1          input beat present
//   in_last    in   1          final beat of packet (ignored for routing when PACKET=0)
//   in_sel     in   SELW       destination channel
//   in_ready   out  1          beat accepted when in_valid & in_ready
//   out_data   out  NCH*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   out_valid  out  NCH        channel k register full
//   out_last   out  NCH        in_last copied with the beat
//   out_ready  in   NCH        consumer k takes beat when out_valid[k] & out_ready[k]
//   err_sel    out  1          one-cycle pulse: beat/packet with in_sel >= NCH was dropped
//   drop_cnt   out  8          saturating count of dropped beats
// BEHAVIOUR
//   Reset (async): out_valid=0, out_data=0, out_last=0, err_sel=0, drop_cnt=0, FSM=IDLE.
//   Route target t: in_sel in IDLE or when PACKET=0; captured lock_sel in LOCK.
//   in_ready = (t invalid) | ~out_valid[t] | out_ready[t]; combinational, no loop on in_valid.
//   Accept: slot t loads in_data/in_last, out_valid[t]=1 next cycle (latency 1 cycle).
//   Simultaneous drain and load of same slot: full throughput, out_valid stays 1, new data.
//   Slot drains on out_valid&out_ready with no load: out_valid->0; data holds last value.
//   out_data/out_last stable while out_valid & ~out_ready. Other channels unaffected by t.
//   FSM (PACKET=1): IDLE --accept non-last, sel valid--> LOCK (lock_sel<=in_sel)
//                   IDLE --accept non-last, sel invalid--> DROP
//                   LOCK/DROP --accept in_last--> IDLE; single-beat packet stays in IDLE.
//   In LOCK, in_sel changes are ignored; in DROP every beat accepted (in_ready=1) and dropped.
//   PACKET=0: FSM stays IDLE; every beat with invalid sel dropped individually.
//   err_sel pulses on the accept cycle of the first dropped beat of a packet (each beat if
//   PACKET=0). drop_cnt +1 per dropped beat, saturates at 255, never wraps.
//   Reset mid-packet: FSM to IDLE, all slots emptied; partial packet lost, no err_sel.
//   NCH power of two with SELW=clog2(NCH): no invalid sel possible; err path still present.
// STRUCTURE
//   dmux_defs.vh: FSM encodings ST_IDLE=2'd0, ST_LOCK=2'd1, ST_DROP=2'd2; DROP_CNT_W=8.
//   Sub-module dmux_out_slot (WIDTH): one-entry valid/ready register with load, last flag;
//   instantiated NCH times in a generate loop. Top holds FSM, lock_sel, decode, counters.
// TESTING
//   Per-beat, PACKET=0, NCH=8: sel=0..7 beats 0xA0..0xA7, all out_ready=1 -> channel k gets
//     0xA0+k one cycle after accept, in_ready constantly 1.
//   Backpressure: out_ready[3]=0, two beats sel=3 -> first held in slot 3, in_ready=0 for the
//     second; sel=5 beat meanwhile accepted; releasing ready[3] delivers both in order.
//   Packet lock: 4-beat packet, in_sel=2 on beat 0 then 6,1,7 -> all 4 beats on channel 2,
//     out_last[2]=1 only with beat 4; FSM returns IDLE.
//   Invalid sel, NCH=6 SELW=3: 3-beat packet sel=7 -> in_ready=1, nothing on outputs,
//     err_sel one pulse on beat 1, drop_cnt=3; 300 dropped beats -> drop_cnt=255.
//   Async reset mid-packet with slots full -> out_valid=0 immediately, next packet sel=1
//     routes normally from IDLE.
//   Drain+load same cycle on channel 0 with ready=1 -> back-to-back beats, no bubble.

Source files
------------

// File: rtl/dmux_stream_pkg.sv
// Shared types and helpers for the dmux_stream valid/ready demultiplexer.
package dmux_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam int unsigned DROP_CNT_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmux_stream_out_slot.sv
// One-entry valid/ready output register with a last flag; load may coincide with drain.
module dmux_stream_out_slot #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    // Data holds its last value when drained without a new load.
    always_comb begin
        valid_d = valid_q & ~out_ready;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/dmux_stream.sv
// Registered N-way valid/ready demultiplexer with optional per-packet routing lock
// and drop accounting for out-of-range selects.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NCH    = 8,
    parameter int unsigned SELW   = 3,
    parameter int unsigned PACKET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [SELW-1:0]       in_sel,
    output logic                  in_ready,
    output logic [NCH*WIDTH-1:0]  out_data,
    output logic [NCH-1:0]        out_valid,
    output logic [NCH-1:0]        out_last,
    input  logic [NCH-1:0]        out_ready,
    output logic                  err_sel,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam bit PKT = (PACKET != 0);

    state_e                state_q, state_d;
    logic [SELW-1:0]       lock_sel_q, lock_sel_d;
    logic                  err_sel_q, err_sel_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [SELW-1:0] route_sel;
    logic            sel_ok;
    logic            dropping;
    logic            accept;
    logic [NCH-1:0]  hit;
    logic [NCH-1:0]  load;
    logic [NCH-1:0]  slot_valid;

    // Target decode and ready: in_ready depends only on the target slot, never on in_valid.
    always_comb begin
        route_sel = (PKT && state_q == ST_LOCK) ? lock_sel_q : in_sel;
        sel_ok    = 32'(route_sel) < NCH;
        dropping  = (PKT && state_q == ST_DROP) || !sel_ok;
        hit       = '0;
        for (int k = 0; k < NCH; k++) begin
            hit[k] = !dropping && (route_sel == SELW'(k));
        end
        in_ready = ~|(hit & slot_valid & ~out_ready);
        accept   = in_valid & in_ready;
        load     = hit & {NCH{accept}};
    end

    // Packet FSM, lock capture and drop accounting.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        err_sel_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            if (dropping) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
            // Only the first dropped beat of a packet flags an error.
            if (!sel_ok && state_q == ST_IDLE) begin
                err_sel_d = 1'b1;
            end
            if (PKT) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!in_last) begin
                            if (sel_ok) begin
                                state_d    = ST_LOCK;
                                lock_sel_d = in_sel;
                            end else begin
                                state_d = ST_DROP;
                            end
                        end
                    end
                    ST_LOCK, ST_DROP: begin
                        if (in_last) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
            err_sel_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            err_sel_q  <= err_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_sel  = err_sel_q;
    assign drop_cnt = drop_cnt_q;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        dmux_stream_out_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .load_data (in_data),
            .load_last (in_last),
            .out_ready (out_ready[k]),
            .out_valid (slot_valid[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH]),
            .out_last  (out_last[k])
        );
    end

    assign out_valid = slot_valid;

endmodule

// File: tb/tb_dmux_stream.sv
// Scoreboard bench for dmux_stream: per-beat instance (NCH=8) and packet instance (NCH=6).
module tb_dmux_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: NCH=8, per-beat routing
    logic [15:0]  a_data;
    logic         a_valid, a_last, a_ready, a_err;
    logic [2:0]   a_sel;
    logic [127:0] a_odata;
    logic [7:0]   a_ovalid, a_olast, a_oready, a_drop;

    // Instance B: NCH=6, packet routing
    logic [15:0]  b_data;
    logic         b_valid, b_last, b_ready, b_err;
    logic [2:0]   b_sel;
    logic [95:0]  b_odata;
    logic [5:0]   b_ovalid, b_olast, b_oready;
    logic [7:0]   b_drop;

    dmux_stream #(.WIDTH(16), .NCH(8), .SELW(3), .PACKET(0)) dut_a (
        .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
        .in_sel(a_sel), .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid),
        .out_last(a_olast), .out_ready(a_oready), .err_sel(a_err), .drop_cnt(a_drop)
    );

    dmux_stream #(.WIDTH(16), .NCH(6), .SELW(3), .PACKET(1)) dut_b (
        .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
        .in_sel(b_sel), .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid),
        .out_last(b_olast), .out_ready(b_oready), .err_sel(b_err), .drop_cnt(b_drop)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int b_err_cnt = 0;
    int a0_pop_cyc[$];
    logic [16:0] qa[8][$];
    logic [16:0] qb[6][$];
    logic [16:0] ea, eb;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every transfer out of any slot.
    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (a_ovalid[k] && a_oready[k]) begin
                if (qa[k].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_unexpected ch%0d: got 0x%0h expected nothing", k, a_odata[k*16 +: 16]);
                end else begin
                    ea = qa[k].pop_front();
                    check($sformatf("a_ch%0d", k), 32'({a_olast[k], a_odata[k*16 +: 16]}), 32'(ea));
                end
                if (k == 0) a0_pop_cyc.push_back(cyc);
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (b_ovalid[k] && b_oready[k]) begin
                if (qb[k].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_unexpected ch%0d: got 0x%0h expected nothing", k, b_odata[k*16 +: 16]);
                end else begin
                    eb = qb[k].pop_front();
                    check($sformatf("b_ch%0d", k), 32'({b_olast[k], b_odata[k*16 +: 16]}), 32'(eb));
                end
            end
        end
        if (b_err) b_err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input logic [2:0] sel, input logic [15:0] d, input logic l, output int waits);
        a_sel = sel; a_data = d; a_last = l; a_valid = 1'b1; waits = 0;
        forever begin
            @(negedge clk);
            if (a_ready) break;
            waits++;
            if (waits > 50) begin
                n_tests++; n_fail++;
                $display("FAIL a_timeout: got no in_ready expected in_ready within 50 cycles");
                a_valid = 1'b0;
                return;
            end
        end
        qa[sel].push_back({l, d});
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] sel, input logic [15:0] d, input logic l,
                          input int exp_ch, output int waits);
        b_sel = sel; b_data = d; b_last = l; b_valid = 1'b1; waits = 0;
        forever begin
            @(negedge clk);
            if (b_ready) break;
            waits++;
            if (waits > 50) begin
                n_tests++; n_fail++;
                $display("FAIL b_timeout: got no in_ready expected in_ready within 50 cycles");
                b_valid = 1'b0;
                return;
            end
        end
        if (exp_ch >= 0) qb[exp_ch].push_back({l, d});
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int e0;
        a_data = '0; a_valid = 0; a_last = 0; a_sel = '0; a_oready = '1;
        b_data = '0; b_valid = 0; b_last = 0; b_sel = '0; b_oready = '1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_a_valid", 32'(a_ovalid), 32'd0);
        check("rst_a_data",  32'(|a_odata), 32'd0);
        check("rst_a_last",  32'(a_olast), 32'd0);
        check("rst_a_err",   32'(a_err), 32'd0);
        check("rst_a_drop",  32'(a_drop), 32'd0);
        check("rst_b_valid", 32'(b_ovalid), 32'd0);
        check("rst_b_data",  32'(|b_odata), 32'd0);
        check("rst_b_drop",  32'(b_drop), 32'd0);
        reset = 1'b0;
        tick(1);

        // Per-beat routing: channel k gets 0xA0+k one cycle after accept.
        for (int k = 0; k < 8; k++) begin
            send_a(3'(k), 16'h00A0 + 16'(k), 1'b0, w);
            check("a_ready_const", 32'(w), 32'd0);
            check("a_latency", 32'(a_ovalid), 32'(8'd1 << k));
        end
        tick(2);

        // Backpressure on channel 3 while channel 5 keeps flowing.
        a_oready[3] = 1'b0;
        send_a(3'd3, 16'h00B0, 1'b0, w);
        check("a_bp_first", 32'(w), 32'd0);
        a_sel = 3'd3; a_data = 16'h00B1; a_last = 1'b0; a_valid = 1'b1;
        @(negedge clk);
        check("a_bp_ready", 32'(a_ready), 32'd0);
        check("a_bp_hold", 32'(a_odata[48 +: 16]), 32'h00B0);
        tick(1);
        a_valid = 1'b0;
        send_a(3'd5, 16'h00B5, 1'b0, w);
        check("a_bp_other", 32'(w), 32'd0);
        check("a_bp_stable_v", 32'(a_ovalid[3]), 32'd1);
        check("a_bp_stable_d", 32'(a_odata[48 +: 16]), 32'h00B0);
        a_oready[3] = 1'b1;
        send_a(3'd3, 16'h00B1, 1'b0, w);
        check("a_bp_release", 32'(w), 32'd0);
        tick(3);

        // Drain and load of channel 0 in the same cycle: no bubbles.
        a0_pop_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            send_a(3'd0, 16'h0070 + 16'(i), 1'b0, w);
            check("a_b2b_ready", 32'(w), 32'd0);
        end
        tick(3);
        check("a_b2b_count", 32'(a0_pop_cyc.size()), 32'd4);
        for (int i = 1; i < 4 && i < a0_pop_cyc.size(); i++)
            check("a_b2b_gap", 32'(a0_pop_cyc[i] - a0_pop_cyc[0]), 32'(i));

        // Packet lock: select changes after beat 0 are ignored.
        send_b(3'd2, 16'h00C0, 1'b0, 2, w);
        send_b(3'd6, 16'h00C1, 1'b0, 2, w);
        send_b(3'd1, 16'h00C2, 1'b0, 2, w);
        send_b(3'd7, 16'h00C3, 1'b1, 2, w);
        send_b(3'd4, 16'h00C4, 1'b1, 4, w);
        tick(3);

        // Invalid select: whole packet dropped, one err pulse.
        e0 = b_err_cnt;
        send_b(3'd7, 16'h00D0, 1'b0, -1, w);
        check("b_drop_ready", 32'(w), 32'd0);
        check("b_err_first", 32'(b_err), 32'd1);
        check("b_drop_1", 32'(b_drop), 32'd1);
        send_b(3'd7, 16'h00D1, 1'b0, -1, w);
        check("b_err_second", 32'(b_err), 32'd0);
        send_b(3'd7, 16'h00D2, 1'b1, -1, w);
        check("b_err_third", 32'(b_err), 32'd0);
        check("b_drop_3", 32'(b_drop), 32'd3);
        // A valid select inside a dropping packet is dropped too.
        send_b(3'd7, 16'h00E0, 1'b0, -1, w);
        send_b(3'd1, 16'h00E1, 1'b1, -1, w);
        check("b_drop_5", 32'(b_drop), 32'd5);
        for (int i = 0; i < 250; i++) send_b(3'd6, 16'(i), 1'b1, -1, w);
        check("b_drop_255", 32'(b_drop), 32'd255);
        for (int i = 0; i < 50; i++) send_b(3'd7, 16'(i), 1'b1, -1, w);
        check("b_drop_sat", 32'(b_drop), 32'd255);
        tick(2);
        check("b_err_count", 32'(b_err_cnt - e0), 32'd302);

        // Reset mid-packet with slots 1 and 3 full, FSM locked on 3.
        b_oready = 6'b110101;
        send_b(3'd1, 16'h00F0, 1'b1, 1, w);
        send_b(3'd3, 16'h00F1, 1'b0, 3, w);
        tick(1);
        check("b_pre_rst_valid", 32'(b_ovalid), 32'h0A);
        #2 reset = 1'b1;
        #1;
        check("b_rst_valid", 32'(b_ovalid), 32'd0);
        check("b_rst_drop", 32'(b_drop), 32'd0);
        check("b_rst_err", 32'(b_err), 32'd0);
        for (int k = 0; k < 6; k++) qb[k].delete();
        @(negedge clk);
        #1 reset = 1'b0;
        b_oready = '1;
        tick(1);
        send_b(3'd1, 16'h00F2, 1'b0, 1, w);
        check("b_post_rst_latency", 32'(b_ovalid), 32'h02);
        send_b(3'd1, 16'h00F3, 1'b1, 1, w);
        check("b_post_rst_err", 32'(b_err), 32'd0);
        tick(3);

        for (int k = 0; k < 8; k++) check($sformatf("a_q%0d_empty", k), 32'(qa[k].size()), 32'd0);
        for (int k = 0; k < 6; k++) check($sformatf("b_q%0d_empty", k), 32'(qb[k].size()), 32'd0);
        check("a_err_never", 32'(a_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
